// File: rtl/fb_stream_fetcher.sv
// Framebuffer engine on the SDRAM side: pattern-fills one of two frame buffers,
// then streams the displayed buffer into the pixel FIFO as read bursts.
module fb_stream_fetcher #(
    parameter int ADDR_W      = 22,
    parameter int DATA_W      = 32,
    parameter int BURST_LEN   = 8,
    parameter int FRAME_WORDS = 96000,
    parameter int BUF0_BASE   = 0,
    parameter int BUF1_BASE   = 131072,
    parameter int FIFO_DEPTH  = 1024,
    parameter int USED_W      = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill_start,
    input  logic              fill_buf,
    input  logic              fill_mode,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              stream_en,
    input  logic              swap_req,
    output logic [1:0]        command,
    output logic [ADDR_W-1:0] data_address,
    output logic [DATA_W-1:0] data_write,
    input  logic [DATA_W-1:0] data_read,
    input  logic              data_read_valid,
    input  logic              data_write_done,
    input  logic [USED_W-1:0] fifo_used,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic              active_buf,
    output logic              fill_done,
    output logic              frame_start,
    output logic              first_data_ready
);

    localparam int OFF_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [1:0]        CMD_IDLE   = 2'd0;
    localparam logic [1:0]        CMD_WRITE  = 2'd1;
    localparam logic [1:0]        CMD_READ   = 2'd2;
    localparam logic [OFF_W-1:0]  LAST_OFF   = OFF_W'(FRAME_WORDS - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(BURST_LEN - 1);
    localparam logic [USED_W:0]   USED_LIMIT = (USED_W + 1)'(FIFO_DEPTH - BURST_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_FILL_GAP,
        S_READ
    } state_t;

    state_t             state;
    logic               fill_buf_q;
    logic               fill_mode_q;
    logic [OFF_W-1:0]   fill_offset;
    logic [OFF_W-1:0]   stream_offset;
    logic [CNT_W-1:0]   burst_cnt;
    logic [CNT_W-1:0]   wr_cnt;
    logic               swap_pending;

    logic [OFF_W-1:0]   fill_next;
    logic [OFF_W-1:0]   stream_next;
    logic               stream_wrap;
    logic               buf_after_wrap;
    logic               fifo_has_room;

    function automatic logic [ADDR_W-1:0] word_addr(input logic b, input logic [OFF_W-1:0] off);
        logic [ADDR_W-1:0] base;
        base = b ? ADDR_W'(BUF1_BASE) : ADDR_W'(BUF0_BASE);
        return base + ADDR_W'(off);
    endfunction

    function automatic logic [DATA_W-1:0] fill_pattern(input logic mode,
                                                       input logic [OFF_W-1:0] off,
                                                       input logic [DATA_W-1:0] value);
        logic [7:0] lo;
        lo = 8'(off);
        return mode ? {(DATA_W / 8){lo}} : value;
    endfunction

    assign fill_next      = fill_offset + OFF_W'(1);
    assign stream_wrap    = (stream_offset == LAST_OFF);
    assign stream_next    = stream_wrap ? '0 : stream_offset + OFF_W'(1);
    assign buf_after_wrap = active_buf ^ (stream_wrap & swap_pending);
    assign fifo_has_room  = ({1'b0, fifo_used} <= USED_LIMIT);

    assign fifo_wr_en   = (command == CMD_READ) && data_read_valid;
    assign fifo_wr_data = data_read;

    // The fill keeps its own offset, so the stream position survives a fill untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            command          <= CMD_IDLE;
            data_address     <= ADDR_W'(BUF0_BASE);
            data_write       <= '0;
            fill_buf_q       <= 1'b0;
            fill_mode_q      <= 1'b0;
            fill_offset      <= '0;
            stream_offset    <= '0;
            burst_cnt        <= '0;
            wr_cnt           <= '0;
            active_buf       <= 1'b0;
            swap_pending     <= 1'b0;
            fill_done        <= 1'b0;
            frame_start      <= 1'b0;
            first_data_ready <= 1'b0;
        end else begin
            fill_done   <= 1'b0;
            frame_start <= 1'b0;
            if (swap_req) begin
                swap_pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (fill_start) begin
                        state        <= S_FILL;
                        command      <= CMD_WRITE;
                        fill_buf_q   <= fill_buf;
                        fill_mode_q  <= fill_mode;
                        fill_offset  <= '0;
                        wr_cnt       <= '0;
                        data_address <= word_addr(fill_buf, '0);
                        data_write   <= fill_pattern(fill_mode, '0, fill_value);
                    end else if (stream_en && fifo_has_room) begin
                        state        <= S_READ;
                        command      <= CMD_READ;
                        burst_cnt    <= LAST_CNT;
                        data_address <= word_addr(active_buf, stream_offset);
                    end
                end

                S_FILL: begin
                    if (data_write_done) begin
                        if (fill_offset == LAST_OFF) begin
                            state        <= S_IDLE;
                            command      <= CMD_IDLE;
                            fill_offset  <= '0;
                            fill_done    <= 1'b1;
                            data_address <= word_addr(active_buf, stream_offset);
                        end else begin
                            fill_offset  <= fill_next;
                            data_address <= word_addr(fill_buf_q, fill_next);
                            data_write   <= fill_pattern(fill_mode_q, fill_next, fill_value);
                            if (wr_cnt == LAST_CNT) begin
                                // One idle command cycle per group leaves the controller a refresh slot.
                                wr_cnt  <= '0;
                                state   <= S_FILL_GAP;
                                command <= CMD_IDLE;
                            end else begin
                                wr_cnt <= wr_cnt + CNT_W'(1);
                            end
                        end
                    end
                end

                S_FILL_GAP: begin
                    state   <= S_FILL;
                    command <= CMD_WRITE;
                end

                S_READ: begin
                    if (data_read_valid) begin
                        stream_offset <= stream_next;
                        data_address  <= word_addr(buf_after_wrap, stream_next);
                        if (stream_wrap) begin
                            frame_start <= 1'b1;
                            if (swap_pending) begin
                                active_buf <= ~active_buf;
                                if (!swap_req) begin
                                    swap_pending <= 1'b0;
                                end
                            end
                        end
                        if (burst_cnt == '0) begin
                            state            <= S_IDLE;
                            command          <= CMD_IDLE;
                            first_data_ready <= 1'b1;
                        end else begin
                            burst_cnt <= burst_cnt - CNT_W'(1);
                        end
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    command <= CMD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_stream_fetcher.sv
// Directed bench for fb_stream_fetcher with a 64-word frame and 8-word bursts;
// the bench plays the SDRAM controller and tracks the expected stream position.
module tb_fb_stream_fetcher;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 32;
    localparam int FRAME  = 64;
    localparam int BURST  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fill_start;
    logic              fill_buf;
    logic              fill_mode;
    logic [DATA_W-1:0] fill_value;
    logic              stream_en;
    logic              swap_req;
    logic [1:0]        command;
    logic [ADDR_W-1:0] data_address;
    logic [DATA_W-1:0] data_write;
    logic [DATA_W-1:0] data_read;
    logic              data_read_valid;
    logic              data_write_done;
    logic [9:0]        fifo_used;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_wr_data;
    logic              active_buf;
    logic              fill_done;
    logic              frame_start;
    logic              first_data_ready;

    int vectors     = 0;
    int miscompares = 0;

    int exp_off     = 0;
    bit exp_buf     = 1'b0;
    bit exp_pend    = 1'b0;
    bit exp_fs      = 1'b0;
    int burst_words = 0;
    int word_seq    = 0;

    fb_stream_fetcher #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST), .FRAME_WORDS(FRAME),
        .BUF0_BASE(0), .BUF1_BASE(131072), .FIFO_DEPTH(1024), .USED_W(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fill_start(fill_start), .fill_buf(fill_buf),
        .fill_mode(fill_mode), .fill_value(fill_value), .stream_en(stream_en),
        .swap_req(swap_req), .command(command), .data_address(data_address),
        .data_write(data_write), .data_read(data_read), .data_read_valid(data_read_valid),
        .data_write_done(data_write_done), .fifo_used(fifo_used), .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data), .active_buf(active_buf), .fill_done(fill_done),
        .frame_start(frame_start), .first_data_ready(first_data_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [ADDR_W-1:0] exp_addr(input bit b, input int off);
        return (b ? 22'd131072 : 22'd0) + 22'(off);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic fillFrame(input bit b, input bit mode, input logic [31:0] value);
        int  writes = 0;
        int  gaps   = 0;
        int  dones  = 0;
        logic [7:0]  lo;
        logic [31:0] want;
        fill_start = 1'b1; fill_buf = b; fill_mode = mode; fill_value = value;
        data_write_done = 1'b1;
        for (int c = 0; c < 200 && dones == 0; c++) begin
            @(posedge clk); #1;
            fill_start = 1'b0;
            if (fill_done) begin
                dones++;
            end else if (command == 2'd1) begin
                lo   = 8'(writes);
                want = mode ? {4{lo}} : value;
                checkOutput("fill_addr", data_address, exp_addr(b, writes));
                checkOutput("fill_data", data_write, want);
                writes++;
            end else if (writes > 0) begin
                gaps++;
                checkOutput("gap_pos", 64'(writes % BURST), 0);
            end
        end
        checkOutput("fill_seen_done", 64'(dones), 1);
        checkOutput("fill_writes", 64'(writes), FRAME);
        checkOutput("fill_gaps", 64'(gaps), FRAME / BURST - 1);
        checkOutput("fill_cmd_idle", command, 0);
        @(posedge clk); #1;
        checkOutput("fill_done_pulse", fill_done, 0);
        data_write_done = 1'b0;
    endtask

    task automatic applyStimulus(input int n, input int swap_at, input int fill_at);
        bit swapped = 1'b0;
        bit filled  = 1'b0;
        bit wrap;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            swap_req = 1'b0; fill_start = 1'b0;
            checkOutput("frame_start", frame_start, exp_fs);
            checkOutput("active_buf", active_buf, exp_buf);
            checkOutput("no_write", command == 2'd1, 0);
            if (command == 2'd2) begin
                checkOutput("rd_addr", data_address, exp_addr(exp_buf, exp_off));
                data_read_valid = 1'b1;
                data_read = 32'hC0DE_0000 + 32'(word_seq);
                word_seq++;
                if (c < n - 1 && exp_off == swap_at && !swapped) begin
                    swap_req = 1'b1; swapped = 1'b1;
                end
                if (c < n - 1 && exp_off == fill_at && !filled) begin
                    fill_start = 1'b1; fill_buf = 1'b0; fill_mode = 1'b1; filled = 1'b1;
                end
                #1;
                checkOutput("wr_en", fifo_wr_en, 1);
                checkOutput("wr_data", fifo_wr_data, data_read);
                burst_words++;
                wrap   = (exp_off == FRAME - 1);
                exp_fs = wrap;
                if (wrap && exp_pend) exp_buf = ~exp_buf;
                if (swap_req) exp_pend = 1'b1;
                else if (wrap) exp_pend = 1'b0;
                exp_off = wrap ? 0 : exp_off + 1;
            end else begin
                data_read_valid = 1'b0;
                #1;
                checkOutput("wr_en_idle", fifo_wr_en, 0);
                if (burst_words != 0) checkOutput("burst_len", 64'(burst_words), BURST);
                burst_words = 0;
                exp_fs = 1'b0;
            end
        end
    endtask

    initial begin
        int saved_off;
        bit hit;
        rst_n = 1'b0; fill_start = 1'b0; fill_buf = 1'b0; fill_mode = 1'b0;
        fill_value = '0; stream_en = 1'b0; swap_req = 1'b0; data_read = '0;
        data_read_valid = 1'b0; data_write_done = 1'b0; fifo_used = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_command", command, 0);
        checkOutput("rst_addr", data_address, 0);
        checkOutput("rst_wdata", data_write, 0);
        checkOutput("rst_active", active_buf, 0);
        checkOutput("rst_fill_done", fill_done, 0);
        checkOutput("rst_frame_start", frame_start, 0);
        checkOutput("rst_first_ready", first_data_ready, 0);
        checkOutput("rst_wr_en", fifo_wr_en, 0);
        rst_n = 1'b1;

        // Incrementing-pattern fill of buffer 0
        fillFrame(1'b0, 1'b1, 32'h0);

        // One word over the room threshold must hold off streaming
        stream_en = 1'b1; fifo_used = 10'd1017;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            checkOutput("full_hold", command, 0);
        end
        checkOutput("first_ready_before", first_data_ready, 0);

        fifo_used = 10'd1016;
        applyStimulus(10, -1, -1);
        checkOutput("first_ready_after", first_data_ready, 1);

        // Stream across two wraps with a swap requested at offset 20
        applyStimulus(160, 20, -1);
        checkOutput("active_after_swap", active_buf, 1);

        // fill_start while a burst is in flight has no effect
        applyStimulus(30, -1, (exp_off + 3) % FRAME);

        stream_en = 1'b0;
        applyStimulus(12, -1, -1);
        checkOutput("drained_idle", command, 0);

        // Fill and stream requested together: fill first, then resume at saved offset
        saved_off = exp_off;
        stream_en = 1'b1;
        fillFrame(1'b1, 1'b0, 32'hA5A5_5A5A);
        checkOutput("resume_offset", 64'(exp_off), 64'(saved_off));
        applyStimulus(20, -1, -1);

        // Reset while word 3 of a burst is on the bus
        hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(posedge clk); #1;
            if (command == 2'd2) begin
                data_read_valid = 1'b1;
                if (burst_words == 3) begin
                    rst_n = 1'b0; hit = 1'b1;
                end else begin
                    burst_words++;
                end
            end else begin
                data_read_valid = 1'b0;
                burst_words = 0;
            end
        end
        checkOutput("reset_word3_reached", hit, 1);
        @(posedge clk); #1;
        checkOutput("mid_rst_command", command, 0);
        checkOutput("mid_rst_wr_en", fifo_wr_en, 0);
        checkOutput("mid_rst_first_ready", first_data_ready, 0);
        checkOutput("mid_rst_addr", data_address, 0);
        checkOutput("mid_rst_active", active_buf, 0);
        rst_n = 1'b1; data_read_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
